// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP acquisition chain (ADC capture, FIFO, filter).
// Provides the sample word width and the ADC capture state encoding.
package dsp_pkg;

  localparam int unsigned SAMPLE_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CS_HOLD  = 3'd3,
    ST_DONE     = 3'd4
  } adc_state_e;

endpackage

// File: rtl/sample_timer.sv
// Conversion pacing timer.
// Counts 0..SAMPLE_PERIOD-1 while enabled and is held at 0 otherwise.
// tick is high whenever enable is high and the count is 0, so the first
// tick lands on the first enabled cycle.
//   clk    : system clock
//   rst    : synchronous active-high reset
//   enable : run the timer
//   tick   : conversion start request
module sample_timer #(
  parameter int unsigned SAMPLE_PERIOD = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int unsigned TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(SAMPLE_PERIOD - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      cnt <= '0;
    end else if (cnt == T_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TW'(1);
    end
  end

  assign tick = enable && (cnt == '0);

endmodule

// File: rtl/adc_spi_capture.sv
// Serial ADC capture front end.
// Periodically runs a 16-bit SPI mode-0 read (MSB first) and hands each
// completed sample to the downstream FIFO as a one-cycle W_En strobe with
// the data on sample_out. Ticks that arrive while a conversion is in flight
// are dropped and flagged on the sticky overrun output.
//   clk, rst    : system clock, synchronous active-high reset
//   enable      : run the sample timer
//   clr_overrun : clear the overrun flag (set wins on a same-cycle clash)
//   adc_miso    : ADC serial data
//   adc_sclk    : SPI clock, idles low
//   adc_cs_n    : SPI chip select, active low
//   sample_out  : last completed sample
//   W_En        : one-cycle write strobe for the FIFO
//   busy        : conversion in progress
//   overrun     : sticky missed-tick flag
module adc_spi_capture
  import dsp_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                clr_overrun,
  input  logic                adc_miso,
  output logic                adc_sclk,
  output logic                adc_cs_n,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                W_En,
  output logic                busy,
  output logic                overrun
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic tick;

  sample_timer #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .tick  (tick)
  );

  adc_state_e          state_q, state_d;
  logic [DW-1:0]       div_q, div_d;
  logic [4:0]          bit_q, bit_d;
  logic                sclk_q, sclk_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;

  logic                cs_n_q, cs_n_d;
  logic                w_en_q, w_en_d;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;

  logic div_end;
  assign div_end = (div_q == DIV_LAST);

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      sclk_q    <= 1'b0;
      shift_q   <= '0;
      cs_n_q    <= 1'b1;
      w_en_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      sample_q  <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      sclk_q    <= sclk_d;
      shift_q   <= shift_d;
      cs_n_q    <= cs_n_d;
      w_en_q    <= w_en_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      sample_q  <= sample_d;
    end
  end

  // Next-state logic. The SCLK level is itself a register, and MISO is
  // captured on the same clock edge that raises it.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sclk_d  = 1'b0;
    shift_d = shift_q;
    unique case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_CS_SETUP;
          div_d   = '0;
        end
      end
      ST_CS_SETUP: begin
        if (div_end) begin
          state_d = ST_SHIFT;
          div_d   = '0;
          bit_d   = '0;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      ST_SHIFT: begin
        sclk_d = sclk_q;
        if (div_end) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            shift_d = {shift_q[SAMPLE_W-2:0], adc_miso};
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 5'd1;
            if (bit_q == 5'd15) begin
              state_d = ST_CS_HOLD;
            end
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      ST_CS_HOLD: begin
        if (div_end) begin
          state_d = ST_DONE;
          div_d   = '0;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up
  // with the state they describe.
  always_comb begin
    cs_n_d   = !(state_d inside {ST_CS_SETUP, ST_SHIFT, ST_CS_HOLD});
    w_en_d   = (state_d == ST_DONE);
    busy_d   = (state_d != ST_IDLE);
    sample_d = (state_d == ST_DONE) ? shift_q : sample_q;
    if (tick && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  assign adc_sclk   = sclk_q;
  assign adc_cs_n   = cs_n_q;
  assign sample_out = sample_q;
  assign W_En       = w_en_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/adc_spi_capture.md
# adc_spi_capture

Front-end acquisition stage of the DSP chain. It periodically runs a 16-bit SPI read from a serial ADC (mode 0, MSB first) and presents each completed sample to the downstream circular-buffer FIFO as a one-cycle write strobe plus data word. It produces no backpressure: the FIFO drops writes while full. This block only paces conversions and flags missed sample ticks.

## Interface
- `CLK_DIV`, 4: `clk` cycles per SCLK half-period; must be ≥ 1.
- `SAMPLE_PERIOD`, 256: `clk` cycles between conversion starts; must be ≥ 34*`CLK_DIV`+2.
- `clk` in 1: single system clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: run the sample timer; low holds the timer at 0.
- `clr_overrun` in 1: synchronous clear of `overrun`.
- `adc_miso` in 1: ADC serial data; the ADC updates it on SCLK falling edges.
- `adc_sclk` out 1: SPI clock, idles low (CPOL=0).
- `adc_cs_n` out 1: chip select, active low.
- `sample_out` out 16: last completed sample; drives FIFO `data_in`.
- `W_En` out 1: one-cycle write strobe; drives FIFO `W_En`.
- `busy` out 1: high while state ≠ IDLE.
- `overrun` out 1: sticky; set when a sample tick arrives while busy.

## Operation
- Reset values:
  - `adc_cs_n`=1, `adc_sclk`=0, `sample_out`=0, `W_En`=0, `busy`=0, `overrun`=0.
  - Timer=0, state=IDLE, shift register=0.
- Timer:
  - Counts 0..`SAMPLE_PERIOD`-1 and wraps while `enable`=1.
  - Forced to 0 while `enable`=0.
  - A tick is asserted when timer==0 and `enable`=1, so the first conversion starts on the first enabled cycle.
- State machine states: IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE.
- IDLE: `cs_n`=1, `sclk`=0. On a tick, go to CS_SETUP.
- CS_SETUP:
  - `cs_n`=0, `sclk`=0, held for `CLK_DIV` cycles.
  - Then go to SHIFT with bit count=0 and half-period counter=0.
- SHIFT:
  - 16 SCLK periods, each `CLK_DIV` cycles low then `CLK_DIV` cycles high.
  - On each cycle where `sclk` goes 0→1, `adc_miso` is shifted into the LSB (shift left), so the first bit ends up as bit 15.
  - After the 16th high phase completes, `sclk` returns to 0; go to CS_HOLD.
- CS_HOLD: `cs_n`=0, `sclk`=0, held for `CLK_DIV` cycles; then go to DONE.
- DONE:
  - Lasts one cycle: `cs_n`=1, `W_En`=1, `sample_out`=shift register. Then go to IDLE.
  - `sample_out` holds its value until the next DONE.
- Overrun:
  - A tick arriving in any state other than IDLE is dropped and sets `overrun`.
  - `clr_overrun` clears it. A same-cycle set and clear resolves to set.
- `enable` deasserted mid-conversion:
  - The current conversion completes normally, including the `W_En` pulse.
  - No new conversion starts.
- `rst` mid-conversion:
  - Next cycle: `cs_n`=1, `sclk`=0, state=IDLE.
  - The partial sample is discarded and no `W_En` is issued.
- Arithmetic: the half-period counter is clog2(`CLK_DIV`) bits wide (minimum 1), the bit counter 5 bits, the timer clog2(`SAMPLE_PERIOD`) bits. All counters are unsigned and wrap only at their defined terminal values.

## Timing
- A tick sampled at cycle T (in IDLE):
  - `cs_n` falls at T+1.
  - First `sclk` rise at T+1+2*`CLK_DIV`.
  - `W_En` high in cycle T+1+34*`CLK_DIV`; with defaults, T+137.
- Conversion occupancy is 34*`CLK_DIV`+1 cycles (not counting the tick cycle). With the parameter rule, back-to-back ticks never overrun while the parameters are legal.
- `W_En` is never high for two consecutive cycles.
- `busy` is high from T+1 through the DONE cycle inclusive.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `dsp_pkg`:
  - `SAMPLE_W`=16.
  - State encodings (IDLE=0, CS_SETUP=1, SHIFT=2, CS_HOLD=3, DONE=4).
  - This package is shared with the FIFO and filter stages.
- One sub-module, `sample_timer`: parameter `SAMPLE_PERIOD`, ports `clk`, `rst`, `enable`, `tick`. The FSM and shift register stay in the top module.

## Test plan
- ADC model returns 0xA53C, `CLK_DIV`=4, `enable` raised at cycle 10 → `cs_n` falls at cycle 11, `W_En` single pulse at cycle 147, `sample_out`=0xA53C.
- Samples 0x0001, 0x8000, 0xFFFF in sequence, `SAMPLE_PERIOD`=256 → three `W_En` pulses exactly 256 cycles apart with matching data; `overrun`=0.
- Checker on SCLK: exactly 16 rising edges per `cs_n` low window; `sclk`=0 whenever `cs_n`=1.
- `enable` dropped at bit 5 of a conversion → that sample still completes with `W_En`=1; no further `cs_n` activity.
- `rst` asserted during SHIFT → next cycle `cs_n`=1, `sclk`=0, `busy`=0; no `W_En` for the aborted sample.
- Bench overrides the timer tick mid-conversion → `overrun`=1 and the tick is ignored; `clr_overrun` pulse → `overrun`=0 next cycle.
